// File: rtl/fighter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fighter_pkg
// Brief   : State codes and body/attack box geometry shared by fighter_ctrl.
// Revision: 2.0 - second generation fighter controller
// ============================================================================
package fighter_pkg;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_FWD         = 4'd1,
    ST_BACK        = 4'd2,
    ST_ATK_START   = 4'd3,
    ST_ATK_ACTIVE  = 4'd4,
    ST_ATK_RECOVER = 4'd5,
    ST_HITSTUN     = 4'd6,
    ST_BLOCKSTUN   = 4'd7
  } state_t;

  // Box offsets relative to posx / POS_Y.
  localparam int c_BODY_X1_OFS  = 37;
  localparam int c_BODY_X2_OFS  = 86;
  localparam int c_HIT_FAR_OFS  = 113;
  localparam int c_HIT_NEAR_OFS = 10;
  localparam int c_HIT_Y1_OFS   = 24;
  localparam int c_HIT_Y2_OFS   = 57;
  localparam int c_BODY_H       = 150;

  localparam int PUSHBACK = 6;

  function automatic logic is_stun(input state_t s);
    return (s == ST_HITSTUN) || (s == ST_BLOCKSTUN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fighter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : fighter_ctrl_if
// Brief   : Player controls in, position/state/collision boxes out.
// Revision: 2.0 - second generation fighter controller
// ============================================================================
interface fighter_ctrl_if #(
  parameter int POS_W = 10
);
  logic             i_frame_tick;
  logic             i_left;
  logic             i_right;
  logic             i_attack;
  logic             i_hit_in;
  logic [POS_W-1:0] o_posx;
  logic [POS_W-1:0] o_posy;
  logic [3:0]       o_state;
  logic             o_hit_taken;
  logic             o_blocked;
  logic             o_hitbox_valid;
  logic [POS_W-1:0] o_hitbox_x1;
  logic [POS_W-1:0] o_hitbox_x2;
  logic [POS_W-1:0] o_hitbox_y1;
  logic [POS_W-1:0] o_hitbox_y2;
  logic [POS_W-1:0] o_hurtbox_x1;
  logic [POS_W-1:0] o_hurtbox_x2;
  logic [POS_W-1:0] o_hurtbox_y1;
  logic [POS_W-1:0] o_hurtbox_y2;

  modport master (
    output i_frame_tick, i_left, i_right, i_attack, i_hit_in,
    input  o_posx, o_posy, o_state, o_hit_taken, o_blocked, o_hitbox_valid,
    input  o_hitbox_x1, o_hitbox_x2, o_hitbox_y1, o_hitbox_y2,
    input  o_hurtbox_x1, o_hurtbox_x2, o_hurtbox_y1, o_hurtbox_y2
  );

  modport slave (
    input  i_frame_tick, i_left, i_right, i_attack, i_hit_in,
    output o_posx, o_posy, o_state, o_hit_taken, o_blocked, o_hitbox_valid,
    output o_hitbox_x1, o_hitbox_x2, o_hitbox_y1, o_hitbox_y2,
    output o_hurtbox_x1, o_hurtbox_x2, o_hurtbox_y1, o_hurtbox_y2
  );
endinterface
`default_nettype wire

// File: rtl/fighter_ctrl_frame_counter.sv
`default_nettype none
// ============================================================================
// Module  : frame_counter
// Brief   : Frames-in-state counter; clears or advances on tick, saturates.
// Revision: 2.0 - second generation fighter controller
// ============================================================================
module frame_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tick,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      if (i_clr) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/fighter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fighter_ctrl
// Brief   : Frame-paced player FSM (walk, 3-phase attack, hit/block stun)
//           with saturated X position and collision boxes.
//           Option macro PUSHBACK_EN: stun frames push the player away.
// Revision: 2.0 - second generation fighter controller
// ============================================================================
module fighter_ctrl
  import fighter_pkg::*;
#(
  parameter int SIDE         = 0,
  parameter int POS_W        = 10,
  parameter int SPEED        = 15,
  parameter int X_MIN        = 50,
  parameter int X_MAX        = 490,
  parameter int START_X0     = 210,
  parameter int START_X1     = 420,
  parameter int POS_Y        = 170,
  parameter int ATK_STARTUP  = 5,
  parameter int ATK_ACTIVE   = 2,
  parameter int ATK_RECOVERY = 16,
  parameter int STUN_FRAMES  = 12,
  parameter int CNT_W        = 8
) (
  input  logic          clk,
  input  logic          rst,
  fighter_ctrl_if.slave bus
);

  localparam logic [POS_W-1:0] c_START_X =
    (SIDE == 0) ? POS_W'(START_X0) : POS_W'(START_X1);
  localparam logic [POS_W-1:0] c_X_MIN = POS_W'(X_MIN);
  localparam logic [POS_W-1:0] c_X_MAX = POS_W'(X_MAX);
  localparam logic signed [POS_W:0] c_X_MIN_S = (POS_W+1)'(X_MIN);
  localparam logic signed [POS_W:0] c_X_MAX_S = (POS_W+1)'(X_MAX);
  localparam int c_FWD_I = (SIDE == 0) ? SPEED : -SPEED;
  localparam logic signed [POS_W:0] c_FWD_STEP = (POS_W+1)'(c_FWD_I);
`ifdef PUSHBACK_EN
  localparam int c_PUSH_I = (SIDE == 0) ? -PUSHBACK : PUSHBACK;
  localparam logic signed [POS_W:0] c_PUSH_STEP = (POS_W+1)'(c_PUSH_I);
`endif
  localparam logic [CNT_W-1:0] c_STARTUP_LAST = CNT_W'(ATK_STARTUP - 1);
  localparam logic [CNT_W-1:0] c_ACTIVE_LAST  = CNT_W'(ATK_ACTIVE - 1);
  localparam logic [CNT_W-1:0] c_RECOVER_LAST = CNT_W'(ATK_RECOVERY - 1);
  localparam logic [CNT_W-1:0] c_STUN_LAST    = CNT_W'(STUN_FRAMES - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic                    w_reenter;
  logic                    w_enter;
  logic                    w_toward;
  logic                    w_away;
  logic [CNT_W-1:0]        w_cnt;
  logic [POS_W-1:0]        r_posx;
  logic [POS_W-1:0]        w_posx_next;
  logic signed [POS_W:0]   w_delta;
  logic signed [POS_W:0]   w_sum;
  logic                    r_hit_taken;
  logic                    r_blocked;

  assign w_toward = (SIDE == 0) ? bus.i_right : bus.i_left;
  assign w_away   = (SIDE == 0) ? bus.i_left  : bus.i_right;

  frame_counter #(
    .CNT_W (CNT_W)
  ) u_frame_counter (
    .clk    (clk),
    .rst    (rst),
    .i_tick (bus.i_frame_tick),
    .i_clr  (w_enter),
    .o_cnt  (w_cnt)
  );

  always_comb begin
    w_next    = r_state;
    w_reenter = 1'b0;
    case (r_state)
      ST_IDLE, ST_FWD, ST_BACK: begin
        if (bus.i_hit_in) begin
          w_next = (r_state == ST_BACK) ? ST_BLOCKSTUN : ST_HITSTUN;
        end else if (bus.i_attack) begin
          w_next = ST_ATK_START;
        end else if (bus.i_left && bus.i_right) begin
          w_next = ST_BACK;
        end else if (w_toward) begin
          w_next = ST_FWD;
        end else if (w_away) begin
          w_next = ST_BACK;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ATK_START: begin
        if (bus.i_hit_in)                 w_next = ST_HITSTUN;
        else if (w_cnt == c_STARTUP_LAST) w_next = ST_ATK_ACTIVE;
      end
      ST_ATK_ACTIVE: begin
        if (bus.i_hit_in)                w_next = ST_HITSTUN;
        else if (w_cnt == c_ACTIVE_LAST) w_next = ST_ATK_RECOVER;
      end
      ST_ATK_RECOVER: begin
        if (bus.i_hit_in)                 w_next = ST_HITSTUN;
        else if (w_cnt == c_RECOVER_LAST) w_next = ST_IDLE;
      end
      ST_HITSTUN, ST_BLOCKSTUN: begin
        // A fresh hit restarts the same stun rather than stacking.
        if (bus.i_hit_in)              w_reenter = 1'b1;
        else if (w_cnt == c_STUN_LAST) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_enter = (w_next != r_state) || w_reenter;

  always_comb begin
    w_delta = '0;
    case (r_state)
      ST_FWD:  w_delta = c_FWD_STEP;
      ST_BACK: w_delta = -c_FWD_STEP;
      default: w_delta = '0;
    endcase
`ifdef PUSHBACK_EN
    if (is_stun(r_state)) w_delta = c_PUSH_STEP;
`endif
    w_sum = $signed({1'b0, r_posx}) + w_delta;
    if (w_sum < c_X_MIN_S) begin
      w_posx_next = c_X_MIN;
    end else if (w_sum > c_X_MAX_S) begin
      w_posx_next = c_X_MAX;
    end else begin
      w_posx_next = w_sum[POS_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_posx      <= c_START_X;
      r_hit_taken <= 1'b0;
      r_blocked   <= 1'b0;
    end else begin
      r_hit_taken <= bus.i_frame_tick && w_enter && (w_next == ST_HITSTUN);
      r_blocked   <= bus.i_frame_tick && w_enter && (w_next == ST_BLOCKSTUN);
      if (bus.i_frame_tick) begin
        r_state <= w_next;
        r_posx  <= w_posx_next;
      end
    end
  end

  assign bus.o_posx         = r_posx;
  assign bus.o_posy         = POS_W'(POS_Y);
  assign bus.o_state        = r_state;
  assign bus.o_hit_taken    = r_hit_taken;
  assign bus.o_blocked      = r_blocked;
  assign bus.o_hitbox_valid = (r_state == ST_ATK_ACTIVE);

  assign bus.o_hurtbox_x1 = r_posx + POS_W'(c_BODY_X1_OFS);
  assign bus.o_hurtbox_x2 = r_posx + POS_W'(c_BODY_X2_OFS);
  assign bus.o_hurtbox_y1 = POS_W'(POS_Y);
  assign bus.o_hurtbox_y2 = POS_W'(POS_Y + c_BODY_H);
  assign bus.o_hitbox_y1  = POS_W'(POS_Y + c_HIT_Y1_OFS);
  assign bus.o_hitbox_y2  = POS_W'(POS_Y + c_HIT_Y2_OFS);

  generate
    if (SIDE == 0) begin : g_hit_faces_right
      assign bus.o_hitbox_x1 = r_posx + POS_W'(c_BODY_X1_OFS);
      assign bus.o_hitbox_x2 = r_posx + POS_W'(c_HIT_FAR_OFS);
    end else begin : g_hit_faces_left
      assign bus.o_hitbox_x1 = r_posx + POS_W'(c_HIT_NEAR_OFS);
      assign bus.o_hitbox_x2 = r_posx + POS_W'(c_BODY_X2_OFS);
    end
  endgenerate

endmodule
`default_nettype wire
